// File: rtl/memacc_pkg.sv
// memacc_pkg: shared types and constants for the memory access unit.
//   memacc_state_t : sequencer states (IDLE, S_RD, V_WR, V_RD, V_LAST)
//   WB_SEL_MEM     : write-back mux select code that marks a load request
//   MEMACC_*       : default geometry (address width, lane width, lane count, beat counter width)
package memacc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_RD   = 3'd1,
        V_WR   = 3'd2,
        V_RD   = 3'd3,
        V_LAST = 3'd4
    } memacc_state_t;

    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    localparam int MEMACC_ADDR_W = 16;
    localparam int MEMACC_LANE_W = 16;
    localparam int MEMACC_LANES  = 8;
    localparam int MEMACC_BEAT_W = $clog2(MEMACC_LANES);

endpackage

// File: rtl/memory_access_unit.sv
// memory_access_unit: memory stage behind the EX/MEM register. Maps scalar and
// vector loads/stores onto a single-port synchronous RAM of LANE_W-bit words.
// Vector operations are split into one beat per lane; mem_stall holds the front
// of the pipeline until the final beat.
//
// Ports:
//   clk, reset (async, active-low)
//   write_memory_enable_a/b_memory            scalar / vector store requests
//   select_writeback_(vector_)data_mux_memory  == WB_SEL_MEM marks scalar / vector load
//   ALUresult_out                              word address (vector base)
//   srcB_memory, vector_srcB_memory            store data
//   mem_addr, mem_we, mem_wdata, mem_rdata     RAM port (read data one cycle after address)
//   mem_stall                                  pipeline hold
//   load_data/load_valid                       scalar load result, one-cycle pulse
//   vector_load_data/vector_load_valid         vector load result, one-cycle pulse
//   misalign_err                               only with MEMACC_ALIGN_CHECK_EN: pulses when an
//                                              unaligned vector request is dropped
//
// Build option: define MEMACC_ALIGN_CHECK_EN to reject vector bases with base[2:0] != 0.
module memory_access_unit
    import memacc_pkg::*;
#(
    parameter int ADDR_W = MEMACC_ADDR_W,
    parameter int LANE_W = MEMACC_LANE_W,
    parameter int LANES  = MEMACC_LANES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_memory_enable_a_memory,
    input  logic                     write_memory_enable_b_memory,
    input  logic [1:0]               select_writeback_data_mux_memory,
    input  logic [1:0]               select_writeback_vector_data_mux_memory,
    input  logic [15:0]              ALUresult_out,
    input  logic [LANE_W-1:0]        srcB_memory,
    input  logic [LANES*LANE_W-1:0]  vector_srcB_memory,
`ifdef MEMACC_ALIGN_CHECK_EN
    output logic                     misalign_err,
`endif
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [LANE_W-1:0]        mem_wdata,
    input  logic [LANE_W-1:0]        mem_rdata,
    output logic                     mem_stall,
    output logic [LANE_W-1:0]        load_data,
    output logic                     load_valid,
    output logic [LANES*LANE_W-1:0]  vector_load_data,
    output logic                     vector_load_valid
);

    localparam int BEAT_W = (LANES == MEMACC_LANES) ? MEMACC_BEAT_W : $clog2(LANES);
    localparam int VEC_W  = LANES * LANE_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);
    localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);

    memacc_state_t       state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [VEC_W-1:0]    wdata_q, wdata_d;
    // The final lane of a vector load is taken straight from mem_rdata, so only LANES-1 entries are buffered.
    logic [LANE_W-1:0]   lane_buf_q [LANES-1];
    logic [LANE_W-1:0]   lane_buf_d [LANES-1];

    logic                vst_req_s, sst_req_s, vld_req_s, sld_req_s, unaligned_s;
    logic [ADDR_W-1:0]   req_addr_s, beat_addr_s;

    logic [ADDR_W-1:0]   mem_addr_s;
    logic                mem_we_s;
    logic [LANE_W-1:0]   mem_wdata_s;
    logic                mem_stall_s;
    logic [LANE_W-1:0]   load_data_s;
    logic                load_valid_s;
    logic [VEC_W-1:0]    vector_load_data_s;
    logic                vector_load_valid_s;
    logic                misalign_s;

    assign vst_req_s   = write_memory_enable_b_memory;
    assign sst_req_s   = write_memory_enable_a_memory;
    assign vld_req_s   = (select_writeback_vector_data_mux_memory == WB_SEL_MEM);
    assign sld_req_s   = (select_writeback_data_mux_memory == WB_SEL_MEM);
    assign req_addr_s  = ALUresult_out[ADDR_W-1:0];
    // Beat addresses wrap modulo 2^ADDR_W.
    assign beat_addr_s = base_q + ADDR_W'(beat_q);

`ifdef MEMACC_ALIGN_CHECK_EN
    assign unaligned_s = (ALUresult_out[2:0] != 3'b000);
`else
    assign unaligned_s = 1'b0;
`endif

    // Next-state, beat sequencing and RAM/result drive for the access sequencer.
    always_comb begin
        state_d             = state_q;
        beat_d              = beat_q;
        base_d              = base_q;
        wdata_d             = wdata_q;
        lane_buf_d          = lane_buf_q;
        mem_addr_s          = '0;
        mem_we_s            = 1'b0;
        mem_wdata_s         = '0;
        mem_stall_s         = 1'b0;
        load_data_s         = '0;
        load_valid_s        = 1'b0;
        vector_load_data_s  = '0;
        vector_load_valid_s = 1'b0;
        misalign_s          = 1'b0;

        case (state_q)
            IDLE: begin
                // Highest-priority request wins; the others are dropped.
                if (vst_req_s) begin
                    if (unaligned_s) begin
                        misalign_s = 1'b1;
                    end else begin
                        // Lane 0 is written straight from the inputs; the rest are latched.
                        mem_addr_s  = req_addr_s;
                        mem_we_s    = 1'b1;
                        mem_wdata_s = vector_srcB_memory[LANE_W-1:0];
                        mem_stall_s = 1'b1;
                        base_d      = req_addr_s;
                        wdata_d     = vector_srcB_memory;
                        beat_d      = ONE_BEAT;
                        state_d     = V_WR;
                    end
                end else if (sst_req_s) begin
                    mem_addr_s  = req_addr_s;
                    mem_we_s    = 1'b1;
                    mem_wdata_s = srcB_memory;
                end else if (vld_req_s) begin
                    if (unaligned_s) begin
                        misalign_s = 1'b1;
                    end else begin
                        mem_addr_s  = req_addr_s;
                        mem_stall_s = 1'b1;
                        base_d      = req_addr_s;
                        beat_d      = ONE_BEAT;
                        state_d     = V_RD;
                    end
                end else if (sld_req_s) begin
                    mem_addr_s  = req_addr_s;
                    mem_stall_s = 1'b1;
                    base_d      = req_addr_s;
                    state_d     = S_RD;
                end else begin
                    state_d = IDLE;
                end
            end

            S_RD: begin
                load_data_s  = mem_rdata;
                load_valid_s = 1'b1;
                state_d      = IDLE;
            end

            V_WR: begin
                mem_addr_s  = beat_addr_s;
                mem_we_s    = 1'b1;
                mem_wdata_s = wdata_q[int'(beat_q)*LANE_W +: LANE_W];
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    mem_stall_s = 1'b1;
                    beat_d      = beat_q + ONE_BEAT;
                end
            end

            V_RD: begin
                // Read data returning now belongs to the address issued on the previous beat.
                mem_addr_s  = beat_addr_s;
                mem_stall_s = 1'b1;
                lane_buf_d[beat_q - ONE_BEAT] = mem_rdata;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = V_LAST;
                end else begin
                    beat_d = beat_q + ONE_BEAT;
                end
            end

            V_LAST: begin
                for (int i = 0; i < LANES - 1; i++) begin
                    vector_load_data_s[i*LANE_W +: LANE_W] = lane_buf_q[i];
                end
                vector_load_data_s[(LANES-1)*LANE_W +: LANE_W] = mem_rdata;
                vector_load_valid_s = 1'b1;
                state_d             = IDLE;
            end

            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Sequencer state, beat counter, latched request and lane buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i < LANES - 1; i++) begin
                lane_buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            lane_buf_q <= lane_buf_d;
        end
    end

    // Outputs are forced to 0 while reset is held, so a request present during reset never reaches the RAM.
    assign mem_addr          = reset ? mem_addr_s          : '0;
    assign mem_we            = reset ? mem_we_s            : 1'b0;
    assign mem_wdata         = reset ? mem_wdata_s         : '0;
    assign mem_stall         = reset ? mem_stall_s         : 1'b0;
    assign load_data         = reset ? load_data_s         : '0;
    assign load_valid        = reset ? load_valid_s        : 1'b0;
    assign vector_load_data  = reset ? vector_load_data_s  : '0;
    assign vector_load_valid = reset ? vector_load_valid_s : 1'b0;
`ifdef MEMACC_ALIGN_CHECK_EN
    assign misalign_err      = reset ? misalign_s          : 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed + randomized bench for memory_access_unit.
// A behavioural RAM drives mem_rdata; a separate reference memory holds the
// contents the bench expects, and every cycle's outputs are predicted from the
// request rules (priority, beat count, wrap-around addressing, result pulses).
// Honours MEMACC_ALIGN_CHECK_EN when defined.
module tb_memory_access_unit;

    localparam int K_SLD  = 0;
    localparam int K_VLD  = 1;
    localparam int K_SST  = 2;
    localparam int K_VST  = 3;
    localparam int K_NONE = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         write_memory_enable_a_memory;
    logic         write_memory_enable_b_memory;
    logic [1:0]   select_writeback_data_mux_memory;
    logic [1:0]   select_writeback_vector_data_mux_memory;
    logic [15:0]  ALUresult_out;
    logic [15:0]  srcB_memory;
    logic [127:0] vector_srcB_memory;
    logic [15:0]  mem_addr;
    logic         mem_we;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_stall;
    logic [15:0]  load_data;
    logic         load_valid;
    logic [127:0] vector_load_data;
    logic         vector_load_valid;
`ifdef MEMACC_ALIGN_CHECK_EN
    logic         misalign_err;
`endif

    bit   [15:0]  ram     [0:65535];
    bit   [15:0]  ref_mem [0:65535];
    logic         pre_we;
    logic [15:0]  pre_addr;
    logic [15:0]  pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_unit dut (
        .clk                                    (clk),
        .reset                                  (reset),
        .write_memory_enable_a_memory           (write_memory_enable_a_memory),
        .write_memory_enable_b_memory           (write_memory_enable_b_memory),
        .select_writeback_data_mux_memory       (select_writeback_data_mux_memory),
        .select_writeback_vector_data_mux_memory(select_writeback_vector_data_mux_memory),
        .ALUresult_out                          (ALUresult_out),
        .srcB_memory                            (srcB_memory),
        .vector_srcB_memory                     (vector_srcB_memory),
`ifdef MEMACC_ALIGN_CHECK_EN
        .misalign_err                           (misalign_err),
`endif
        .mem_addr                               (mem_addr),
        .mem_we                                 (mem_we),
        .mem_wdata                              (mem_wdata),
        .mem_rdata                              (mem_rdata),
        .mem_stall                              (mem_stall),
        .load_data                              (load_data),
        .load_valid                             (load_valid),
        .vector_load_data                       (vector_load_data),
        .vector_load_valid                      (vector_load_valid)
    );

    // Synchronous single-port RAM, read-first, with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples every output on the falling edge, then advances to just after the next rising edge.
    task automatic expect_cycle(input string tag, input logic [15:0] ea, input logic ewe,
                                input logic [15:0] ewd, input logic est, input logic [15:0] eld,
                                input logic elv, input logic [127:0] evd, input logic evv,
                                input logic emis);
        @(negedge clk);
        chk({tag, " mem_addr"},   128'(mem_addr),          128'(ea));
        chk({tag, " mem_we"},     128'(mem_we),            128'(ewe));
        chk({tag, " mem_wdata"},  128'(mem_wdata),         128'(ewd));
        chk({tag, " mem_stall"},  128'(mem_stall),         128'(est));
        chk({tag, " load_data"},  128'(load_data),         128'(eld));
        chk({tag, " load_valid"}, 128'(load_valid),        128'(elv));
        chk({tag, " vload_data"}, vector_load_data,        evd);
        chk({tag, " vload_valid"},128'(vector_load_valid), 128'(evv));
`ifdef MEMACC_ALIGN_CHECK_EN
        chk({tag, " misalign"},   128'(misalign_err),      128'(emis));
`else
        if (emis) $display("note: misalign expectation ignored in this build");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        expect_cycle(tag, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 128'h0, 1'b0, 1'b0);
    endtask

    // Drop all requests and put junk on address/data so that latching is exercised.
    task automatic scramble();
        write_memory_enable_a_memory            = 1'b0;
        write_memory_enable_b_memory            = 1'b0;
        select_writeback_data_mux_memory        = 2'b00;
        select_writeback_vector_data_mux_memory = 2'b00;
        ALUresult_out      = 16'($urandom);
        srcB_memory        = 16'($urandom);
        vector_srcB_memory = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        idle_cycle("preload");
        pre_we = 1'b0;
    endtask

    // Applies one set of request inputs and checks the whole resulting transaction.
    task automatic run_op(input logic vst, input logic sst, input logic [1:0] sel_v,
                          input logic [1:0] sel_s, input logic [15:0] addr,
                          input logic [15:0] sd, input logic [127:0] vd, input string tag);
        int           kind;
        logic         drop;
        logic [15:0]  a;
        logic [127:0] ev;
        write_memory_enable_b_memory            = vst;
        write_memory_enable_a_memory            = sst;
        select_writeback_vector_data_mux_memory = sel_v;
        select_writeback_data_mux_memory        = sel_s;
        ALUresult_out      = addr;
        srcB_memory        = sd;
        vector_srcB_memory = vd;
        if (vst)                kind = K_VST;
        else if (sst)           kind = K_SST;
        else if (sel_v == 2'b01) kind = K_VLD;
        else if (sel_s == 2'b01) kind = K_SLD;
        else                    kind = K_NONE;
        drop = 1'b0;
`ifdef MEMACC_ALIGN_CHECK_EN
        drop = (kind == K_VST || kind == K_VLD) && (addr[2:0] != 3'b000);
`endif
        if (drop) begin
            expect_cycle({tag, "/drop"}, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 128'h0, 1'b0, 1'b1);
            scramble();
        end else begin
            case (kind)
                K_SST: begin
                    expect_cycle({tag, "/sst"}, addr, 1'b1, sd, 1'b0, 16'h0, 1'b0, 128'h0, 1'b0, 1'b0);
                    ref_mem[addr] = sd;
                    scramble();
                end
                K_SLD: begin
                    expect_cycle({tag, "/sld0"}, addr, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 128'h0, 1'b0, 1'b0);
                    scramble();
                    expect_cycle({tag, "/sld1"}, 16'h0, 1'b0, 16'h0, 1'b0, ref_mem[addr], 1'b1, 128'h0, 1'b0, 1'b0);
                end
                K_VST: begin
                    for (int k = 0; k < 8; k++) begin
                        a = addr + 16'(k);
                        expect_cycle($sformatf("%s/vst%0d", tag, k), a, 1'b1, vd[k*16 +: 16],
                                     (k < 7), 16'h0, 1'b0, 128'h0, 1'b0, 1'b0);
                        ref_mem[a] = vd[k*16 +: 16];
                        if (k == 0) scramble();
                    end
                end
                K_VLD: begin
                    for (int i = 0; i < 8; i++) ev[i*16 +: 16] = ref_mem[16'(addr + 16'(i))];
                    for (int k = 0; k < 8; k++) begin
                        a = addr + 16'(k);
                        expect_cycle($sformatf("%s/vld%0d", tag, k), a, 1'b0, 16'h0, 1'b1,
                                     16'h0, 1'b0, 128'h0, 1'b0, 1'b0);
                        if (k == 0) scramble();
                    end
                    expect_cycle({tag, "/vld_res"}, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, ev, 1'b1, 1'b0);
                end
                default: begin
                    idle_cycle({tag, "/none"});
                    scramble();
                end
            endcase
        end
    endtask

    initial begin
        logic [127:0] vd;
        logic [15:0]  a;

        // Reset held with a store request present: nothing may reach the RAM.
        reset  = 1'b0;
        pre_we = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
        scramble();
        write_memory_enable_a_memory = 1'b1;
        ALUresult_out = 16'h0055;
        repeat (2) @(posedge clk);
        #1;
        idle_cycle("reset");
        scramble();
        reset = 1'b1;
        idle_cycle("after_reset");

        // Scalar store, scalar load.
        run_op(1'b0, 1'b1, 2'b00, 2'b00, 16'h0010, 16'hBEEF, 128'h0, "sst");
        preload(16'h0020, 16'h1234);
        run_op(1'b0, 1'b0, 2'b00, 2'b01, 16'h0020, 16'h0, 128'h0, "sld");
        run_op(1'b0, 1'b0, 2'b00, 2'b01, 16'h0010, 16'h0, 128'h0, "sld_back");

        // Vector store of lane indices, then read it back.
        for (int i = 0; i < 8; i++) vd[i*16 +: 16] = 16'(i);
        run_op(1'b1, 1'b0, 2'b00, 2'b00, 16'h0100, 16'h0, vd, "vst");
        run_op(1'b0, 1'b0, 2'b01, 2'b00, 16'h0100, 16'h0, 128'h0, "vld_back");

        // Vector load wrapping past the top of the address space.
        for (int i = 0; i < 8; i++) begin
            a = 16'hFFFC + 16'(i);
            preload(a, 16'h00A0 + 16'(i));
        end
        run_op(1'b0, 1'b0, 2'b01, 2'b00, 16'hFFFC, 16'h0, 128'h0, "vld_wrap");
        run_op(1'b1, 1'b0, 2'b00, 2'b00, 16'hFFFE, 16'h0, {$urandom, $urandom, $urandom, $urandom}, "vst_wrap");

        // Priority between simultaneous requests; 2'b10/2'b11 selects are not load requests.
        run_op(1'b1, 1'b1, 2'b01, 2'b01, 16'h0140, 16'h5A5A, {$urandom, $urandom, $urandom, $urandom}, "prio_all");
        run_op(1'b0, 1'b1, 2'b01, 2'b01, 16'h0141, 16'hA5A5, 128'h0, "prio_sst");
        run_op(1'b0, 1'b0, 2'b01, 2'b01, 16'h0140, 16'h0, 128'h0, "prio_vld");
        run_op(1'b0, 1'b0, 2'b10, 2'b11, 16'h0140, 16'h0, 128'h0, "no_req");

        // Vector store with a competing scalar store, aborted by reset at beat 4.
        vd = {$urandom, $urandom, $urandom, $urandom};
        write_memory_enable_b_memory = 1'b1;
        write_memory_enable_a_memory = 1'b1;
        ALUresult_out      = 16'h0200;
        srcB_memory        = 16'h7777;
        vector_srcB_memory = vd;
        for (int k = 0; k < 4; k++) begin
            a = 16'h0200 + 16'(k);
            expect_cycle($sformatf("abort/vst%0d", k), a, 1'b1, vd[k*16 +: 16], 1'b1,
                         16'h0, 1'b0, 128'h0, 1'b0, 1'b0);
            ref_mem[a] = vd[k*16 +: 16];
            if (k == 0) scramble();
        end
        reset = 1'b0;
        repeat (2) idle_cycle("abort/in_reset");
        reset = 1'b1;
        repeat (3) idle_cycle("abort/post_reset");
        run_op(1'b0, 1'b0, 2'b00, 2'b01, 16'h0200, 16'h0, 128'h0, "abort/lane0");
        run_op(1'b0, 1'b0, 2'b00, 2'b01, 16'h0203, 16'h0, 128'h0, "abort/lane3");
        run_op(1'b0, 1'b0, 2'b00, 2'b01, 16'h0204, 16'h0, 128'h0, "abort/lane4");

        // Unaligned vector base (dropped when the alignment check is built in).
        run_op(1'b0, 1'b0, 2'b01, 2'b00, 16'h0103, 16'h0, 128'h0, "vld_unaligned");
        run_op(1'b1, 1'b0, 2'b00, 2'b00, 16'h0305, 16'h0, {$urandom, $urandom, $urandom, $urandom}, "vst_unaligned");
        idle_cycle("after_unaligned");

        // Randomized request mix over two small address windows.
        for (int n = 0; n < 60; n++) begin
            logic [15:0]  ra;
            logic [127:0] rv;
            ra = ($urandom_range(0, 1) == 0) ? (16'h0300 + 16'($urandom_range(0, 63)))
                                             : (16'hFFF0 + 16'($urandom_range(0, 15)));
            rv = {$urandom, $urandom, $urandom, $urandom};
            run_op($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   ra, 16'($urandom), rv, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
